// File: rtl/dense_mac_scheduler_pkg.sv
// Shared types and helpers for the dense classifier sequencer: FSM encoding,
// clog2-derived widths and the sign-extension helper used by the datapath.
package dense_mac_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_DRAIN,
    ST_BIAS,
    ST_EMIT,
    ST_FIN
  } state_e;

  // Width of a counter/index covering 0..n-1; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_INPUT_SIZE   = 676;
  localparam int DEF_OUTPUT_SIZE  = 10;
  localparam int DEF_DATA_WIDTH   = 20;
  localparam int DEF_WEIGHT_WIDTH = 8;
  localparam int DEF_ACC_WIDTH    = 32;
  localparam int DEF_WADDR_W      = clog2_min1(DEF_INPUT_SIZE * DEF_OUTPUT_SIZE);
  localparam int DEF_CLASS_W      = clog2_min1(DEF_OUTPUT_SIZE);

  // Treat the low w bits of v as a signed value and sign-extend it to 64 bits.
  function automatic logic [63:0] sext64(input logic [63:0] v, input int w);
    logic [6:0] sh;
    sh = 7'(64 - w);
    return $signed(v << sh) >>> sh;
  endfunction

endpackage

// File: rtl/dense_mac_unit.sv
// Shared multiply-accumulate datapath: one signed multiplier feeding a bank of
// per-class accumulators, with an alternate bias-add path.
module dense_mac_unit
  import dense_mac_scheduler_pkg::*;
#(
  parameter int OUTPUT_SIZE  = DEF_OUTPUT_SIZE,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
  parameter int IDX_W        = clog2_min1(OUTPUT_SIZE)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_clear,
  input  logic                                  i_en,
  input  logic                                  i_sel_bias,
  input  logic [IDX_W-1:0]                      i_idx,
  input  logic [DATA_WIDTH-1:0]                 i_feature,
  input  logic [WEIGHT_WIDTH-1:0]               i_weight,
  input  logic [WEIGHT_WIDTH-1:0]               i_bias,
  output logic [OUTPUT_SIZE-1:0][ACC_WIDTH-1:0] o_acc
);

  localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;

  logic signed [PROD_W-1:0]            w_prod;
  logic [ACC_WIDTH-1:0]                w_addend;
  logic [OUTPUT_SIZE-1:0][ACC_WIDTH-1:0] r_acc;

  assign w_prod = $signed(i_feature) * $signed(i_weight);

  always_comb begin
    // NOTE: combinational outputs get a value on every path, so no latch is inferred.
    w_addend = ACC_WIDTH'(sext64(64'(w_prod), PROD_W));
    if (i_sel_bias) begin
      w_addend = ACC_WIDTH'(sext64(64'(i_bias), WEIGHT_WIDTH));
    end
  end

  // NOTE: the accumulator bank is a handful of registers, not a RAM, so it is
  // reset; an abandoned inference must not leak partial sums into the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      // NOTE: state updates are non-blocking so every register samples pre-edge values.
      r_acc[i_idx] <= r_acc[i_idx] + w_addend;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/dense_mac_scheduler.sv
// Fully connected classifier sequencer: streams features in, time-shares one
// multiplier across all classes, adds biases, then emits scores and argmax.
module dense_mac_scheduler
  import dense_mac_scheduler_pkg::*;
#(
  parameter int INPUT_SIZE   = DEF_INPUT_SIZE,
  parameter int OUTPUT_SIZE  = DEF_OUTPUT_SIZE,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
  localparam int WADDR_W     = clog2_min1(INPUT_SIZE * OUTPUT_SIZE),
  localparam int CLS_W       = clog2_min1(OUTPUT_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   feature_in,
  input  logic                    feature_valid,
  output logic                    feature_ready,
  output logic [WADDR_W-1:0]      weight_addr,
  input  logic [WEIGHT_WIDTH-1:0] weight_data,
  output logic [CLS_W-1:0]        bias_addr,
  input  logic [WEIGHT_WIDTH-1:0] bias_data,
  output logic [ACC_WIDTH-1:0]    score_out,
  output logic [CLS_W-1:0]        score_class,
  output logic                    score_valid,
  input  logic                    score_ready,
  output logic [CLS_W-1:0]        pred_class,
  output logic                    busy,
  output logic                    done
);

  localparam int FI_W  = clog2_min1(INPUT_SIZE);
  localparam int CNT_W = clog2_min1(OUTPUT_SIZE + 1);

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   LAST_CLS  = CNT_W'(OUTPUT_SIZE - 1);
  localparam logic [CNT_W-1:0]   BIAS_END  = CNT_W'(OUTPUT_SIZE);
  localparam logic [CLS_W-1:0]   CLS_ONE   = CLS_W'(1);
  localparam logic [CLS_W-1:0]   LAST_IDX  = CLS_W'(OUTPUT_SIZE - 1);
  localparam logic [FI_W-1:0]    FI_ONE    = FI_W'(1);
  localparam logic [FI_W-1:0]    LAST_FEAT = FI_W'(INPUT_SIZE - 1);
  localparam logic [WADDR_W-1:0] W_STEP    = WADDR_W'(INPUT_SIZE);

  state_e                         r_state;
  logic [FI_W-1:0]                r_feat_idx;
  logic [CNT_W-1:0]               r_cnt;
  logic [DATA_WIDTH-1:0]          r_feature;
  logic signed [ACC_WIDTH-1:0]    r_max;
  logic [CLS_W-1:0]               r_max_idx;

  logic                           w_clear;
  logic                           w_acc_en;
  logic                           w_sel_bias;
  logic [CLS_W-1:0]               w_wr_idx;
  logic [OUTPUT_SIZE-1:0][ACC_WIDTH-1:0] w_acc;
  logic                           w_take;
  logic signed [ACC_WIDTH-1:0]    w_max_next;
  logic [CLS_W-1:0]               w_max_idx_next;
  logic [CLS_W-1:0]               w_next_cls;

  dense_mac_unit #(
    .OUTPUT_SIZE (OUTPUT_SIZE),
    .DATA_WIDTH  (DATA_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH),
    .IDX_W       (CLS_W)
  ) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_clear),
    .i_en      (w_acc_en),
    .i_sel_bias(w_sel_bias),
    .i_idx     (w_wr_idx),
    .i_feature (r_feature),
    .i_weight  (weight_data),
    .i_bias    (bias_data),
    .o_acc     (w_acc)
  );

  assign w_clear = (r_state == ST_IDLE) && start;

  // ROM data lags its address by one cycle, so the write index trails r_cnt by one.
  always_comb begin
    w_acc_en   = 1'b0;
    w_sel_bias = 1'b0;
    w_wr_idx   = '0;
    case (r_state)
      ST_MAC: begin
        if (r_cnt != '0) begin
          w_acc_en = 1'b1;
          w_wr_idx = CLS_W'(r_cnt - CNT_ONE);
        end
      end
      ST_DRAIN: begin
        w_acc_en = 1'b1;
        w_wr_idx = LAST_IDX;
      end
      ST_BIAS: begin
        if (r_cnt != '0) begin
          w_acc_en   = 1'b1;
          w_sel_bias = 1'b1;
          w_wr_idx   = CLS_W'(r_cnt - CNT_ONE);
        end
      end
      default: ;
    endcase
  end

  // Running argmax; a strictly greater score is needed to displace the leader.
  assign w_take         = (score_class == '0) || ($signed(score_out) > r_max);
  assign w_max_next     = w_take ? $signed(score_out) : r_max;
  assign w_max_idx_next = w_take ? score_class : r_max_idx;
  assign w_next_cls     = score_class + CLS_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_feat_idx    <= '0;
      r_cnt         <= '0;
      r_feature     <= '0;
      r_max         <= '0;
      r_max_idx     <= '0;
      feature_ready <= 1'b0;
      weight_addr   <= '0;
      bias_addr     <= '0;
      score_out     <= '0;
      score_class   <= '0;
      score_valid   <= 1'b0;
      pred_class    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_feat_idx    <= '0;
            feature_ready <= 1'b1;
            busy          <= 1'b1;
            r_state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (feature_valid) begin
            r_feature     <= feature_in;
            feature_ready <= 1'b0;
            r_cnt         <= '0;
            weight_addr   <= WADDR_W'(r_feat_idx);
            r_state       <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (r_cnt == LAST_CLS) begin
            r_state <= ST_DRAIN;
          end else begin
            weight_addr <= weight_addr + W_STEP;
          end
          r_cnt <= r_cnt + CNT_ONE;
        end
        ST_DRAIN: begin
          if (r_feat_idx == LAST_FEAT) begin
            r_cnt     <= '0;
            bias_addr <= '0;
            r_state   <= ST_BIAS;
          end else begin
            r_feat_idx    <= r_feat_idx + FI_ONE;
            feature_ready <= 1'b1;
            r_state       <= ST_LOAD;
          end
        end
        ST_BIAS: begin
          if (r_cnt == BIAS_END) begin
            score_out   <= w_acc[0];
            score_class <= '0;
            score_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end else if (r_cnt < LAST_CLS) begin
            bias_addr <= bias_addr + CLS_ONE;
          end
          r_cnt <= r_cnt + CNT_ONE;
        end
        ST_EMIT: begin
          if (score_ready) begin
            r_max     <= w_max_next;
            r_max_idx <= w_max_idx_next;
            if (score_class == LAST_IDX) begin
              score_valid <= 1'b0;
              pred_class  <= w_max_idx_next;
              done        <= 1'b1;
              r_state     <= ST_FIN;
            end else begin
              score_class <= w_next_cls;
              score_out   <= w_acc[w_next_cls];
            end
          end
        end
        ST_FIN: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
